// File: rtl/pong_pkg.sv
// Shared definitions for the pong input path: button FSM state encoding,
// default timing constants and a counter-width helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // 25 MHz pixel clock: 10 ms debounce, 500 ms first repeat, 100 ms cadence.
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_RATE     = 2500000;

    function automatic int cnt_width(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Bundle between the raw paddle buttons and the conditioned outputs seen by pong.
interface btn_cond_if;
    logic btn_up_raw;
    logic btn_down_raw;
    logic btn_up;
    logic btn_down;
    logic up_pulse;
    logic down_pulse;

    modport master (
        output btn_up_raw, btn_down_raw,
        input  btn_up, btn_down, up_pulse, down_pulse
    );

    modport slave (
        input  btn_up_raw, btn_down_raw,
        output btn_up, btn_down, up_pulse, down_pulse
    );
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchroniser, debounce counter and auto-repeat FSM.
// Outputs are the next-cycle level and unmasked pulse; the parent registers them.
//
// state     | meaning
// ST_IDLE   | level low, waiting for a debounced press
// ST_HOLD   | pressed, counting down the initial repeat delay
// ST_REPEAT | still pressed, strobing every REPEAT_RATE cycles
module btn_chan
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic vga_clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level_next,
    output logic o_pulse_next
);

    localparam int W_DEB = cnt_width(DEBOUNCE_CYCLES);
    localparam int W_TMR = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

    localparam logic [W_DEB-1:0] DEB_TC     = W_DEB'(DEBOUNCE_CYCLES - 1);
    localparam logic [W_DEB-1:0] DEB_ONE    = W_DEB'(1);
    localparam logic [W_TMR-1:0] DELAY_LOAD = W_TMR'(REPEAT_DELAY - 1);
    localparam logic [W_TMR-1:0] RATE_LOAD  = W_TMR'(REPEAT_RATE - 1);
    localparam logic [W_TMR-1:0] TMR_ONE    = W_TMR'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [W_DEB-1:0] r_deb_cnt;
    logic [W_TMR-1:0] r_tmr;
    btn_state_t       r_state;

    logic             w_level_next;
    logic [W_DEB-1:0] w_deb_cnt_next;
    logic [W_TMR-1:0] w_tmr_next;
    btn_state_t       w_state_next;
    logic             w_pulse_next;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
            r_tmr     <= '0;
            r_state   <= ST_IDLE;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level   <= w_level_next;
            r_deb_cnt <= w_deb_cnt_next;
            r_tmr     <= w_tmr_next;
            r_state   <= w_state_next;
        end
    end

    // Counter only survives while the synced input keeps disagreeing with the level.
    always_comb begin
        w_level_next   = r_level;
        w_deb_cnt_next = '0;
        if (r_sync2 != r_level) begin
            if (r_deb_cnt == DEB_TC) begin
                w_level_next = ~r_level;
            end else begin
                w_deb_cnt_next = r_deb_cnt + DEB_ONE;
            end
        end
    end

    // Release is checked before the timer so a simultaneous release never strobes.
    always_comb begin
        w_state_next = r_state;
        w_tmr_next   = r_tmr;
        w_pulse_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_level_next && !r_level) begin
                    w_state_next = ST_HOLD;
                    w_tmr_next   = DELAY_LOAD;
                    w_pulse_next = 1'b1;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!w_level_next) begin
                    w_state_next = ST_IDLE;
                end else if (r_tmr == '0) begin
                    w_state_next = ST_REPEAT;
                    w_tmr_next   = RATE_LOAD;
                    w_pulse_next = 1'b1;
                end else begin
                    w_tmr_next = r_tmr - TMR_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_level_next = w_level_next;
    assign o_pulse_next = w_pulse_next;

endmodule

// File: rtl/btn_cond.sv
// Paddle button conditioning: two debounced/auto-repeat channels plus
// up/down conflict masking in front of the registered outputs.
module btn_cond
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic      vga_clk,
    input  logic      rst,
    btn_cond_if.slave bus
);

    logic w_up_level_next;
    logic w_up_pulse_next;
    logic w_dn_level_next;
    logic w_dn_pulse_next;

    logic r_btn_up;
    logic r_btn_down;
    logic r_up_pulse;
    logic r_down_pulse;

    btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_up (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .i_raw        (bus.btn_up_raw),
        .o_level_next (w_up_level_next),
        .o_pulse_next (w_up_pulse_next)
    );

    btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_dn (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .i_raw        (bus.btn_down_raw),
        .o_level_next (w_dn_level_next),
        .o_pulse_next (w_dn_pulse_next)
    );

    // Mask against the opposite level as it will read this cycle, so the very
    // first conflicting cycle is already silent.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_btn_up     <= 1'b0;
            r_btn_down   <= 1'b0;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
        end else begin
            r_btn_up     <= w_up_level_next;
            r_btn_down   <= w_dn_level_next;
            r_up_pulse   <= w_up_pulse_next & ~w_dn_level_next;
            r_down_pulse <= w_dn_pulse_next & ~w_up_level_next;
        end
    end

    assign bus.btn_up     = r_btn_up;
    assign bus.btn_down   = r_btn_down;
    assign bus.up_pulse   = r_up_pulse;
    assign bus.down_pulse = r_down_pulse;

endmodule
